mod_acc_1481: RTL and testbench
===============================

// Module: mod_acc_1481
// PURPOSE
// Streaming modular accumulator, directly downstream of the mod-1481 Barrett reduction stage.
// - Consumes 11-bit residues from the reducer and sums FRAME_LEN of them modulo Q=1481.
// - Emits one fully reduced sum per frame, using valid/ready on both sides.
// - Accepts non-canonical inputs (0..2047), because a single conditional subtract can leave the
//   reducer output >= Q; every emitted sum is canonical.
// PARAMETERS
// Q          1481   modulus
// W          11     residue width, ceil(log2(Q))
// FRAME_LEN  256    samples per frame, >=1
// CNT_W      8      sample counter width, ceil(log2(FRAME_LEN)), minimum 1
// PORTS
// clk        in   1   single clock, rising edge
// rst        in   1   asynchronous, active-high reset
// in_valid   in   1   din_r is valid
// in_ready   out  1   block can accept din_r this cycle
// din_r      in   W   residue from Barrett stage, 0..2^W-1
// out_valid  out  1   dout_sum holds a completed frame sum
// out_ready  in   1   consumer accepts dout_sum
// dout_sum   out  W   frame sum mod Q, always 0..Q-1
// BEHAVIOUR
// - Reset (async assert; release sampled on clk): state=ACC, acc=0, cnt=0, out_valid=0,
//   dout_sum=0, in_ready=1.
// - FSM has two states.
//   ACC:  in_ready=1, out_valid=0. On each in_valid&in_ready: acc<=modadd(acc,din_r), cnt<=cnt+1.
//         If cnt==FRAME_LEN-1 on that beat: dout_sum<=modadd(acc,din_r), acc<=0, cnt<=0,
//         go to HOLD.
//   HOLD: in_ready=0, out_valid=1, dout_sum stable. On out_ready: go to ACC next cycle.
//         in_valid is ignored in HOLD, and no input is consumed there.
// - modadd(a,x): s=a+x is W+1 bits, max 1480+2047=3527 < 3Q.
//   - If s>=2Q, subtract 2Q; else if s>=Q, subtract Q.
//   - Result is always < Q. No wrap or overflow is possible.
// - Latency: the last sample accepted on edge t gives out_valid=1 after edge t
//   (registered, 1 cycle).
// - Throughput: with out_ready=1, exactly one in_ready=0 bubble per frame (the HOLD cycle).
// - FRAME_LEN=1: every accepted sample goes straight to HOLD with dout_sum=modadd(0,din_r).
// - in_valid low mid-frame: acc and cnt hold; there is no timeout.
// - Reset mid-frame or during HOLD: the partial sum is discarded, out_valid drops immediately
//   (async), and the next frame starts at cnt=0.
// - dout_sum changes only on entry to HOLD. Outside HOLD it holds the previous value and is
//   don't-care to the consumer.
// - No combinational path from out_ready to in_ready; both are pure state decodes.
// STRUCTURE
// - Shared package mod1481_pkg: Q, W, 2Q constant, and the state enum {ACC,HOLD}.
//   The Barrett stage and this block draw Q and W from that same package.
// - Sub-module mod_add_1481 (combinational): inputs a[W-1:0] (canonical) and x[W-1:0]
//   (0..2^W-1); output s[W-1:0] canonical, using the two-level conditional subtract above.
// - Top level holds the FSM, acc and cnt registers, the dout_sum register and the handshake
//   decode.
// TESTING (FRAME_LEN=4 unless noted; ref model = sum mod 1481)
// 1. Max canonical: 1480,1480,1480,1480 back-to-back -> dout_sum=1477 (5920-3*1481),
//    out_valid 1 cycle after 4th beat.
// 2. Non-canonical: 2047,0,0,0 -> dout_sum=566. Also 2047,2047,2047,2047 -> 8188 mod 1481 = 783.
// 3. Backpressure: frame 1,2,3,4 with out_ready=0 for 5 cycles -> dout_sum=10 stable,
//    out_valid=1, in_ready=0 throughout; release -> ACC next cycle.
// 4. Gapped input: frame 100,200,300,400 with in_valid low 3 cycles between beats -> 1000;
//    cnt does not advance while idle.
// 5. Reset mid-frame: accept 500,600, assert rst 1 cycle, then 1,2,3,4 -> dout_sum=10.
//    Reset during HOLD -> out_valid=0 at once.
// 6. Streaming: 64 random frames, out_ready=1 -> results match model; exactly 1 bubble/frame.
//    Repeat with random out_ready and FRAME_LEN=1.

Source files
------------

// File: rtl/mod1481_pkg.sv
// Shared constants for the mod-1481 datapath (Barrett stage and accumulator).
// Provides Q, W, 2Q and the accumulator FSM state type.
package mod1481_pkg;

   localparam int unsigned Q  = 1481;
   localparam int unsigned W  = 11;
   localparam int unsigned Q2 = 2 * Q;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/mod_add_1481.sv
// Combinational modular add: s = (a + x) mod Q.
// Ports: a (canonical, 0..Q-1), x (any W-bit value), s (canonical result).
module mod_add_1481
   import mod1481_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] x,
   output logic [W-1:0] s
);

   localparam logic [W:0] Q_S  = (W+1)'(Q);
   localparam logic [W:0] Q2_S = (W+1)'(Q2);

   logic [W:0] sum;

   // a < Q and x < 2^W keep the sum below 3Q, so at most
   // one of the two subtractions is ever needed.
   always_comb begin
      sum = {1'b0, a} + {1'b0, x};
      if (sum >= Q2_S) begin
         s = W'(sum - Q2_S);
      end else if (sum >= Q_S) begin
         s = W'(sum - Q_S);
      end else begin
         s = W'(sum);
      end
   end

endmodule

// File: rtl/mod_acc_1481.sv
// Streaming frame accumulator: sums FRAME_LEN residues modulo Q.
// Ports: clk, rst (async high); in_valid/in_ready/din_r input stream;
// out_valid/out_ready/dout_sum output, one canonical sum per frame.
module mod_acc_1481
   import mod1481_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 256,
   parameter int unsigned CNT_W     = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] din_r,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] dout_sum
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

   state_t           state_q;
   state_t           state_d;
   logic [W-1:0]     acc_q;
   logic [W-1:0]     sum_q;
   logic [W-1:0]     sum_w;
   logic [CNT_W-1:0] cnt_q;
   logic             beat;
   logic             last_beat;

   mod_add_1481 u_add (
      .a (acc_q),
      .x (din_r),
      .s (sum_w)
   );

   assign beat      = in_valid & in_ready;
   assign last_beat = beat & (cnt_q == LAST);
   assign dout_sum  = sum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // Handshake outputs are pure state decodes, so out_ready
   // never reaches in_ready combinationally.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ACC: begin
            in_ready = 1'b1;
            if (last_beat) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         sum_q <= '0;
      end else if (beat) begin
         if (cnt_q == LAST) begin
            acc_q <= '0;
            cnt_q <= '0;
            sum_q <= sum_w;
         end else begin
            acc_q <= sum_w;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mod_acc_1481.sv
// Self-checking bench for mod_acc_1481 (FRAME_LEN=4 and FRAME_LEN=1).
// Reference model: plain integer sum of each frame, then % 1481.
module tb_mod_acc_1481;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [10:0] a_din, a_dout;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [10:0] b_din, b_dout;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   mod_acc_1481 #(.FRAME_LEN(4), .CNT_W(2)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .din_r     (a_din),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .dout_sum  (a_dout)
   );

   mod_acc_1481 #(.FRAME_LEN(1), .CNT_W(1)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .din_r     (b_din),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .dout_sum  (b_dout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame_a(input int v0, input int v1,
                               input int v2, input int v3);
      int v[4];
      v = '{v0, v1, v2, v3};
      a_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_din = 11'(v[i]);
         step();
      end
      a_in_valid = 1'b0;
   endtask

   task automatic release_a();
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_in_valid = 0; a_out_ready = 0; a_din = '0;
      b_in_valid = 0; b_out_ready = 0; b_din = '0;
      repeat (2) step();
      rst = 1'b0;
      step();
      n_chk++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_a_hs ov=%b ir=%b exp ov=0 ir=1", a_out_valid, a_in_ready);
      end
      n_chk++;
      if (a_dout !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_a_dout got %0d exp 0", a_dout);
      end
      n_chk++;
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_dout !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_b ov=%b ir=%b dout=%0d exp 0/1/0", b_out_valid, b_in_ready, b_dout);
      end
   endtask

   task automatic test_max_canonical();
      send_frame_a(1480, 1480, 1480, 1480);
      n_chk++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL max_latency ov=%b ir=%b exp ov=1 ir=0", a_out_valid, a_in_ready);
      end
      n_chk++;
      if (a_dout !== 11'd1477) begin
         n_fail++;
         $display("FAIL max_sum got %0d exp 1477", a_dout);
      end
      release_a();
      n_chk++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL max_release ov=%b ir=%b exp ov=0 ir=1", a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_noncanonical();
      send_frame_a(2047, 0, 0, 0);
      n_chk++;
      if (a_out_valid !== 1'b1 || a_dout !== 11'd566) begin
         n_fail++;
         $display("FAIL noncanon_one ov=%b got %0d exp 566", a_out_valid, a_dout);
      end
      release_a();
      send_frame_a(2047, 2047, 2047, 2047);
      n_chk++;
      if (a_out_valid !== 1'b1 || a_dout !== 11'd783) begin
         n_fail++;
         $display("FAIL noncanon_all ov=%b got %0d exp 783", a_out_valid, a_dout);
      end
      release_a();
   endtask

   task automatic test_backpressure();
      send_frame_a(1, 2, 3, 4);
      a_in_valid = 1'b1;
      a_din = 11'd999;
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_dout !== 11'd10) begin
            n_fail++;
            $display("FAIL bp_hold cyc %0d ov=%b ir=%b dout=%0d exp 1/0/10",
                     i, a_out_valid, a_in_ready, a_dout);
         end
         step();
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      n_chk++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release ir=%b ov=%b exp ir=1 ov=0", a_in_ready, a_out_valid);
      end
   endtask

   task automatic test_gapped();
      int v[4];
      v = '{100, 200, 300, 400};
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1;
         a_din = 11'(v[i]);
         step();
         a_in_valid = 1'b0;
         a_din = 11'd2047;
         repeat (3) step();
      end
      repeat (7) step();
      n_chk++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL gap_idle ov=%b ir=%b exp ov=0 ir=1", a_out_valid, a_in_ready);
      end
      a_in_valid = 1'b1;
      a_din = 11'(v[3]);
      step();
      a_in_valid = 1'b0;
      n_chk++;
      if (a_out_valid !== 1'b1 || a_dout !== 11'd1000) begin
         n_fail++;
         $display("FAIL gap_sum ov=%b got %0d exp 1000", a_out_valid, a_dout);
      end
      release_a();
   endtask

   task automatic test_reset_midframe();
      a_in_valid = 1'b1;
      a_din = 11'd500;
      step();
      a_din = 11'd600;
      step();
      a_in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_chk++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid ir=%b ov=%b exp ir=1 ov=0", a_in_ready, a_out_valid);
      end
      send_frame_a(1, 2, 3, 4);
      n_chk++;
      if (a_out_valid !== 1'b1 || a_dout !== 11'd10) begin
         n_fail++;
         $display("FAIL rst_mid_sum ov=%b got %0d exp 10", a_out_valid, a_dout);
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if (a_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_hold_async ov=%b exp 0", a_out_valid);
      end
      step();
      rst = 1'b0;
      step();
      n_chk++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_hold_after ir=%b ov=%b exp ir=1 ov=0", a_in_ready, a_out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int exp_q[$];
      int msum = 0;
      int mcnt = 0;
      int got = 0;
      int bubbles = 0;
      int cyc = 0;
      int e;
      a_out_ready = 1'b1;
      a_in_valid = 1'b1;
      a_din = 11'($urandom_range(0, 2047));
      while (got < 64 && cyc < 1000) begin
         if (!a_in_ready) bubbles++;
         if (a_out_valid && a_out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL stream_a_extra got %0d exp none", a_dout);
            end else begin
               e = exp_q.pop_front();
               if (int'(a_dout) != e) begin
                  n_fail++;
                  $display("FAIL stream_a_sum frame %0d got %0d exp %0d", got, a_dout, e);
               end
            end
            got++;
         end
         if (a_in_valid && a_in_ready) begin
            msum += int'(a_din);
            mcnt++;
            if (mcnt == 4) begin
               exp_q.push_back(msum % 1481);
               msum = 0;
               mcnt = 0;
            end
         end
         step();
         cyc++;
         a_din = 11'($urandom_range(0, 2047));
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b0;
      n_chk++;
      if (got != 64 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stream_a_count got %0d frames exp 64 (pending %0d)", got, exp_q.size());
      end
      n_chk++;
      if (bubbles != 64 || cyc != 320) begin
         n_fail++;
         $display("FAIL stream_a_bubbles got %0d in %0d cyc exp 64 in 320", bubbles, cyc);
      end
   endtask

   task automatic test_frame_len_one();
      int exp_q[$];
      int got = 0;
      int cyc = 0;
      int e;
      b_in_valid = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_din = 11'($urandom_range(0, 2047));
      while (got < 64 && cyc < 2000) begin
         n_chk++;
         if (b_in_ready === b_out_valid) begin
            n_fail++;
            $display("FAIL len1_hs ir=%b ov=%b exp complementary", b_in_ready, b_out_valid);
         end
         if (b_out_valid && b_out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL len1_extra got %0d exp none", b_dout);
            end else begin
               e = exp_q.pop_front();
               if (int'(b_dout) != e) begin
                  n_fail++;
                  $display("FAIL len1_sum item %0d got %0d exp %0d", got, b_dout, e);
               end
            end
            got++;
         end
         if (b_in_valid && b_in_ready)
            exp_q.push_back(int'(b_din) % 1481);
         step();
         cyc++;
         b_in_valid = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         b_din = 11'($urandom_range(0, 2047));
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b0;
      n_chk++;
      if (got != 64) begin
         n_fail++;
         $display("FAIL len1_count got %0d exp 64", got);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_max_canonical();
      test_noncanonical();
      test_backpressure();
      test_gapped();
      test_reset_midframe();
      test_back_to_back();
      test_frame_len_one();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
